// File: rtl/hilo_mult_ctrl_if.sv
// hilo_mult_ctrl_if: decode-side bundle for the Hi/Lo multiply sequencer
// master (decode) drives Start/Signal/dataA/dataB; slave (sequencer) drives HiOut/LoOut/Busy/Done/Stall
interface hilo_mult_ctrl_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             Busy;
  logic             Done;
  logic             Stall;
  modport master (output Start, Signal, dataA, dataB, input HiOut, LoOut, Busy, Done, Stall);
  modport slave (input Start, Signal, dataA, dataB, output HiOut, LoOut, Busy, Done, Stall);
endinterface

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl: shift-add multiply sequencer owning the Hi/Lo register pair
// clk, reset (sync, active-high); bus.slave: Start/Signal/dataA/dataB in, HiOut/LoOut/Busy/Done/Stall out
// Optional MULT_SIGNED_EN: also accept signed MULT via magnitude multiply and final negation
module hilo_mult_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  hilo_mult_ctrl_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [5:0] F_MULTU = 6'b011001, F_MULT = 6'b011000, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo, w_opa, w_opb;
  logic [2*WIDTH-1:0] r_p, w_p_next, w_prod;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic               w_is_mult, w_is_mul, w_accept, w_last;
`ifdef MULT_SIGNED_EN
  logic r_sign;
  assign w_is_mult = bus.Signal == F_MULT;
  assign w_opa     = (w_is_mult && bus.dataA[WIDTH-1]) ? ~bus.dataA + 1'b1 : bus.dataA;
  assign w_opb     = (w_is_mult && bus.dataB[WIDTH-1]) ? ~bus.dataB + 1'b1 : bus.dataB;
  assign w_prod    = r_sign ? ~w_p_next + 1'b1 : w_p_next;
`else
  assign w_is_mult = 1'b0;
  assign w_opa     = bus.dataA;
  assign w_opb     = bus.dataB;
  assign w_prod    = w_p_next;
`endif
  assign w_is_mul  = bus.Signal == F_MULTU || w_is_mult;
  assign w_accept  = bus.Start && w_is_mul && r_state != MUL;
  assign w_last    = r_cnt == CW'(WIDTH - 1);
  // carry out of the add becomes the new top bit as P shifts right
  assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_p[0]}} & {1'b0, r_mcand});
  assign w_p_next  = {w_sum, r_p[WIDTH-1:1]};
  assign bus.HiOut = r_hi;
  assign bus.LoOut = r_lo;
  assign bus.Busy  = r_state == MUL;
  assign bus.Done  = r_state == DONE;
  assign bus.Stall = bus.Start && bus.Busy && (w_is_mul || bus.Signal == F_MFHI || bus.Signal == F_MFLO);
  always_comb begin
    w_next = r_state;
    w_next = r_state == MUL ? (w_last ? DONE : MUL) : (w_accept ? MUL : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULT_SIGNED_EN
      r_sign  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mcand <= w_opa;
        r_p     <= {{WIDTH{1'b0}}, w_opb};
        r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
        r_sign  <= w_is_mult && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
`endif
      end else if (r_state == MUL) begin
        r_p   <= w_p_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl: randomized scoreboard bench for hilo_mult_ctrl
module tb_hilo_mult_ctrl;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001, F_MULT = 6'b011000, F_MFHI = 6'b010000,
                         F_MFLO = 6'b010010, F_DIVU = 6'b011011, F_ADDU = 6'b100001, F_SLL = 6'b000000;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; int acc; int done;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int acc_c = -1, free_c = 0;
  exp_t exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  hilo_mult_ctrl_if #(.WIDTH(W)) bus();
  hilo_mult_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  function automatic bit is_mul(logic [5:0] f);
    return f == F_MULTU || (SIGNED_EN && f == F_MULT);
  endfunction
  function automatic bit is_stall_f(logic [5:0] f);
    return is_mul(f) || f == F_MFHI || f == F_MFLO;
  endfunction
  function automatic logic [63:0] prod(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return f == F_MULT ? 64'(sa * sb) : 64'(a) * 64'(b);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_hi = '0;
      m_lo = '0;
    end else begin
      bit busy_e, done_e, stall_e;
      busy_e  = exp_q.size() > 0 && cyc > exp_q[0].acc && cyc < exp_q[0].done;
      done_e  = exp_q.size() > 0 && cyc == exp_q[0].done;
      stall_e = bus.Start && busy_e && is_stall_f(bus.Signal);
      chk("busy", 64'(bus.Busy), 64'(busy_e));
      chk("done", 64'(bus.Done), 64'(done_e));
      chk("stall", 64'(bus.Stall), 64'(stall_e));
      if (done_e) begin
        m_hi = exp_q[0].hi;
        m_lo = exp_q[0].lo;
        void'(exp_q.pop_front());
      end
      chk("hi", 64'(bus.HiOut), 64'(m_hi));
      chk("lo", 64'(bus.LoOut), 64'(m_lo));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int k);
    bus.Start = 1'b0;
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic issue(logic [5:0] f, logic [W-1:0] a, logic [W-1:0] b);
    logic [63:0] p;
    bus.Start = 1'b1;
    bus.Signal = f;
    bus.dataA = a;
    bus.dataB = b;
    if (is_stall_f(f))
      while (cyc > acc_c && cyc < free_c) step();
    if (is_mul(f)) begin
      p = prod(f, a, b);
      exp_q.push_back('{p[63:32], p[31:0], cyc, cyc + W + 1});
      acc_c = cyc;
      free_c = cyc + W + 1;
    end
    step();
    bus.Start = 1'b0;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
  endtask
  task automatic do_reset(int k);
    reset = 1'b1;
    bus.Start = 1'b0;
    acc_c = -1;
    free_c = 0;
    for (int i = 0; i < k; i++) step();
    reset = 1'b0;
  endtask
  function automatic logic [W-1:0] pick_op();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? '0 : r == 1 ? W'(1) : r == 2 ? '1 : r == 3 ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
  endfunction
  initial begin
    logic [5:0] fs[8];
    fs = '{F_MULTU, F_MULTU, F_MULT, F_MFHI, F_MFLO, F_DIVU, F_ADDU, F_SLL};
    bus.Start = 1'b0;
    bus.Signal = F_SLL;
    bus.dataA = '0;
    bus.dataB = '0;
    do_reset(2);
    idle(2);
    issue(F_MULTU, 32'd3, 32'd5);
    idle(W + 2);
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(W + 2);
    issue(F_MULTU, $urandom, $urandom);
    idle(4);
    issue(F_MFHI, $urandom, $urandom);
    idle(2);
    issue(F_MULTU, $urandom, $urandom);
    idle(9);
    do_reset(1);
    idle(W + 4);
    issue(F_MULTU, 32'd7, 32'd9);
    idle(W + 2);
    issue(F_MULT, 32'hFFFFFFFE, 32'd3);
    idle(W + 2);
    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, W + 2));
      if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 2));
      issue(fs[$urandom_range(0, 7)], pick_op(), pick_op());
    end
    idle(W + 4);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
